// File: rtl/npc_pkg.sv
// Shared definitions for the NPC multi-cycle core: RV32 opcodes, FSM state type and halt codes.
package npc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0]  F3_ADD      = 3'b000;
    localparam logic [6:0]  F7_ADD      = 7'b0000000;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [4:0]  A0_IDX      = 5'd10;

    localparam logic [1:0] HALT_EBREAK   = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL  = 2'd1;
    localparam logic [1:0] HALT_MISALIGN = 2'd2;

    typedef enum logic [2:0] {
        FETCH_REQ,
        FETCH_WAIT,
        EXEC,
        WB,
        HALT
    } npc_state_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/npc_multicycle_core_regfile.sv
// Architectural register file: two combinational read ports, one clocked write port, x0 hardwired to zero.
module npc_regfile #(
    parameter int NR_REGS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [4:0]            raddr2,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int AW = $clog2(NR_REGS);

    logic [DATA_WIDTH-1:0] regs [NR_REGS];

    function automatic logic mapped(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NR_REGS);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
        end else if (we && mapped(waddr)) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    // Unmapped indices read as zero; the core flags them illegal before they matter.
    assign rdata1 = mapped(raddr1) ? regs[raddr1[AW-1:0]] : '0;
    assign rdata2 = mapped(raddr2) ? regs[raddr2[AW-1:0]] : '0;

endmodule

// File: rtl/npc_multicycle_core.sv
// NPC multi-cycle RV32 core: valid/ready fetch, decode/execute, writeback, halt reporting.
// Build option NPC_MISALIGN_TRAP_EN: halt on jump targets with bit 1 set instead of aligning them.
//
//   state      | meaning
//   FETCH_REQ  | request pc from instruction memory, hold until accepted
//   FETCH_WAIT | wait for the instruction word, latch it into ir
//   EXEC       | decode ir, read operands, decide halt or proceed
//   WB         | write rd, advance pc, pulse commit
//   HALT       | stopped until reset
module npc_multicycle_core
    import npc_pkg::*;
#(
    parameter int          NR_REGS    = 32,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] pc,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        halted,
    output logic [1:0]  halt_code,
    output logic [31:0] halt_a0
);

    npc_state_t  state, state_n;
    logic [31:0] ir;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2, rf_raddr2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] result, jump_tgt, next_pc;
    logic        is_legal, is_ebreak, is_jump, add_legal, misalign, rf_we;
    logic [1:0]  halt_code_n;

    function automatic logic reg_ok(input logic [4:0] idx);
        return int'(idx) < NR_REGS;
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = sext12(ir[31:20]);
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign add_legal = (opcode == OP_OP) && (funct3 == F3_ADD) && (funct7 == F7_ADD)
                    && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
    // Port 2 serves rs2 only for add; every halting instruction reads a0 through it instead.
    assign rf_raddr2 = add_legal ? rs2 : A0_IDX;

    npc_regfile #(
        .NR_REGS    (NR_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .rdata1 (rs1_val),
        .raddr2 (rf_raddr2),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (result)
    );

    always_comb begin
        is_legal  = 1'b0;
        is_ebreak = 1'b0;
        is_jump   = 1'b0;
        result    = '0;
        jump_tgt  = '0;
        case (opcode)
            OP_LUI: begin
                is_legal = reg_ok(rd);
                result   = imm_u;
            end
            OP_AUIPC: begin
                is_legal = reg_ok(rd);
                result   = pc + imm_u;
            end
            OP_IMM: begin
                is_legal = (funct3 == F3_ADD) && reg_ok(rd) && reg_ok(rs1);
                result   = rs1_val + imm_i;
            end
            OP_OP: begin
                is_legal = add_legal;
                result   = rs1_val + rs2_val;
            end
            OP_JAL: begin
                is_legal = reg_ok(rd);
                is_jump  = 1'b1;
                result   = pc + 32'd4;
                jump_tgt = pc + imm_j;
            end
            OP_JALR: begin
                is_legal = (funct3 == F3_ADD) && reg_ok(rd) && reg_ok(rs1);
                is_jump  = 1'b1;
                result   = pc + 32'd4;
                jump_tgt = (rs1_val + imm_i) & ~32'd1;
            end
            OP_SYSTEM: is_ebreak = (ir == INSN_EBREAK);
            default: ;
        endcase
    end

`ifdef NPC_MISALIGN_TRAP_EN
    assign misalign = is_jump && jump_tgt[1];
    assign next_pc  = is_jump ? jump_tgt : pc + 32'd4;
`else
    assign misalign = 1'b0;
    assign next_pc  = is_jump ? {jump_tgt[31:2], 2'b00} : pc + 32'd4;
`endif

    assign halt_code_n = is_ebreak ? HALT_EBREAK : (!is_legal ? HALT_ILLEGAL : HALT_MISALIGN);
    assign rf_we       = (state == WB) && (rd != 5'd0);
    assign imem_addr   = pc;

    always_comb begin
        state_n = state;
        case (state)
            FETCH_REQ:  if (imem_req_valid && imem_req_ready) state_n = FETCH_WAIT;
            FETCH_WAIT: if (imem_rsp_valid) state_n = EXEC;
            EXEC:       state_n = (is_ebreak || !is_legal || misalign) ? HALT : WB;
            WB:         state_n = FETCH_REQ;
            HALT:       state_n = HALT;
            default:    state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH_REQ;
        else      state <= state_n;
    end

    // Status outputs are registered from the next state so they sit at zero throughout reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= RESET_PC;
            ir             <= '0;
            imem_req_valid <= 1'b0;
            commit_valid   <= 1'b0;
            commit_pc      <= '0;
            halted         <= 1'b0;
            halt_code      <= HALT_EBREAK;
            halt_a0        <= '0;
        end else begin
            imem_req_valid <= (state_n == FETCH_REQ);
            commit_valid   <= (state_n == WB);
            if (state == FETCH_WAIT && imem_rsp_valid) ir <= imem_rsp_data;
            if (state == EXEC && state_n == WB) commit_pc <= pc;
            if (state == WB) pc <= next_pc;
            if (state == EXEC && state_n == HALT) begin
                halted    <= 1'b1;
                halt_code <= halt_code_n;
                halt_a0   <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_npc_multicycle_core.sv
// Scoreboard bench for npc_multicycle_core (NR_REGS = 16): expected fetch/commit addresses queued per program.
module tb_npc_multicycle_core;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic [31:0] pc, commit_pc, halt_a0;
    logic        commit_valid, halted;
    logic [1:0]  halt_code;

    always #5 clk = ~clk;

    npc_multicycle_core #(
        .NR_REGS    (16),
        .RESET_PC   (BASE),
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc             (pc),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .halted         (halted),
        .halt_code      (halt_code),
        .halt_a0        (halt_a0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] add_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] auipc(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0010111};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    // Memory model and scoreboard monitor share one negedge process so cycle stamps stay consistent.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_fetch[$];
    logic [31:0] exp_commit[$];
    int          acc_cyc[$];
    int          extra_fetch = 0, extra_commit = 0, cyc = 0, lat = 1, pend_cnt = 0;
    logic        pend = 1'b0, inject_stale = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : EBREAK;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (imem_req_valid && imem_req_ready) begin
                acc_cyc.push_back(cyc);
                if (exp_fetch.size() > 0) check("fetch_addr", imem_addr, exp_fetch.pop_front());
                else extra_fetch++;
            end
            if (commit_valid) begin
                if (exp_commit.size() > 0) check("commit_pc", commit_pc, exp_commit.pop_front());
                else extra_commit++;
            end
        end
        imem_rsp_valid = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (inject_stale) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = addi(5'd10, 5'd0, 12'd99);
                inject_stale   = 1'b0;
            end else if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_rd(pend_addr);
                    pend           = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = imem_addr;
            end
        end
    end

    task automatic start_test(input logic ready_init);
        rst = 1'b0;
        mem.delete();
        acc_cyc.delete();
        extra_fetch    = 0;
        extra_commit   = 0;
        lat            = 1;
        inject_stale   = 1'b0;
        imem_req_ready = ready_init;
        repeat (2) @(posedge clk);
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        mem[BASE + 32'(idx * 4)] = w;
    endtask

    task automatic finish_test(input string name, input logic [1:0] code, input logic [31:0] a0);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        check({name, "_halt_code"}, 32'(halt_code), 32'(code));
        check({name, "_halt_a0"}, halt_a0, a0);
        repeat (4) @(negedge clk);
        check({name, "_halt_sticky"}, 32'(halted), 32'd1);
        check({name, "_halt_req_idle"}, 32'(imem_req_valid), 32'd0);
        check({name, "_fetch_missing"}, 32'(exp_fetch.size()), 32'd0);
        check({name, "_commit_missing"}, 32'(exp_commit.size()), 32'd0);
        check({name, "_fetch_extra"}, 32'(extra_fetch), 32'd0);
        check({name, "_commit_extra"}, 32'(extra_commit), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        #2;

        // Reset values, then addi/ebreak with always-ready memory.
        start_test(1'b1);
        check("rst_pc", pc, BASE);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_pc", commit_pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_halt_code", 32'(halt_code), 32'd0);
        check("rst_halt_a0", halt_a0, 32'd0);
        put(0, addi(5'd10, 5'd0, 12'd5));
        put(1, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        finish_test("t1", 2'd0, 32'd5);
        gap = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1;
        check("t1_fetch_gap", 32'(gap), 32'd4);

        // Request held without ready for three extra cycles.
        start_test(1'b0);
        put(0, addi(5'd10, 5'd0, 12'h123));
        put(1, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        n = 0;
        while (!imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t2_hold_addr", imem_addr, BASE);
        end
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        finish_test("t2", 2'd0, 32'h123);

        // 32-bit wraparound: x1 = 0xFFFFF000 + 0x7FF + 0x7FF + 2 = 0.
        start_test(1'b1);
        put(0, addi(5'd10, 5'd0, 12'hFFF));
        put(1, lui(5'd1, 20'hFFFFF));
        put(2, addi(5'd1, 5'd1, 12'h7FF));
        put(3, addi(5'd1, 5'd1, 12'h7FF));
        put(4, addi(5'd1, 5'd1, 12'd2));
        put(5, add_r(5'd10, 5'd1, 5'd1));
        put(6, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd16, BASE + 32'd20, BASE + 32'd24};
        exp_commit = {BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd16, BASE + 32'd20};
        #1 rst = 1'b1;
        finish_test("t3", 2'd0, 32'd0);

        start_test(1'b1);
        put(0, auipc(5'd10, 20'h00001));
        put(1, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        finish_test("t3b", 2'd0, 32'h8000_1000);

        // jal x1,+8 skips one word and links pc+4.
        start_test(1'b1);
        put(0, jal(5'd1, 21'd8));
        put(1, addi(5'd10, 5'd0, 12'd1));
        put(2, add_r(5'd10, 5'd1, 5'd0));
        put(3, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd8, BASE + 32'd12};
        exp_commit = {BASE, BASE + 32'd8};
        #1 rst = 1'b1;
        finish_test("t4", 2'd0, 32'h8000_0004);

        // Register index beyond the 16-entry file, then an undefined opcode.
        start_test(1'b1);
        put(0, addi(5'd10, 5'd0, 12'd3));
        put(1, addi(5'd20, 5'd0, 12'd1));
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        finish_test("t5", 2'd1, 32'd3);

        start_test(1'b1);
        put(0, addi(5'd10, 5'd0, 12'd4));
        put(1, 32'h0000_0000);
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        finish_test("t5b", 2'd1, 32'd4);

        // jalr x0,2(x0): trap or align to address 0 (which holds ebreak).
        start_test(1'b1);
        put(0, addi(5'd10, 5'd0, 12'd9));
        put(1, jalr(5'd0, 5'd0, 12'd2));
`ifdef NPC_MISALIGN_TRAP_EN
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        finish_test("t6", 2'd2, 32'd9);
`else
        exp_fetch  = {BASE, BASE + 32'd4, 32'h0000_0000};
        exp_commit = {BASE, BASE + 32'd4};
        #1 rst = 1'b1;
        finish_test("t6", 2'd0, 32'd9);
`endif

        // Reset while waiting for a slow response, then a stale response after release.
        start_test(1'b1);
        put(0, addi(5'd10, 5'd0, 12'd7));
        put(1, addi(5'd10, 5'd10, 12'd1));
        put(2, EBREAK);
        exp_fetch  = {BASE, BASE + 32'd4};
        exp_commit = {BASE};
        #1 rst = 1'b1;
        n = 0;
        while (exp_commit.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = 6;
        n = 0;
        while (exp_fetch.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t7_pre_fetches", 32'(exp_fetch.size()), 32'd0);
        @(posedge clk);
        #1;
        check("t7_pre_pc", pc, BASE + 32'd4);
        check("t7_pre_commit_pc", commit_pc, BASE);
        rst = 1'b0;
        #1;
        check("t7_async_pc", pc, BASE);
        check("t7_async_commit_pc", commit_pc, 32'd0);
        check("t7_async_req_valid", 32'(imem_req_valid), 32'd0);
        exp_fetch  = {BASE, BASE + 32'd4, BASE + 32'd8};
        exp_commit = {BASE, BASE + 32'd4};
        lat = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        inject_stale = 1'b1;
        finish_test("t7", 2'd0, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
